// File: rtl/spi_cfg_master_if.sv
// Requester-side handshake bundle for spi_cfg_master.
// Two independent write requesters, each with valid/addr/data toward the
// master and ready back from it.
//   master modport : requester view (drives valid/addr/data, sees ready)
//   slave  modport : spi_cfg_master view (sees valid/addr/data, drives ready)
interface spi_cfg_master_if;
   logic       req0_valid;
   logic [6:0] req0_addr;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [6:0] req1_addr;
   logic [7:0] req1_data;
   logic       req1_ready;

   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready
   );
endinterface

// File: rtl/spi_cfg_master.sv
// Two-requester round-robin SPI write master (SPI mode 0).
// Each accepted request becomes a 16-bit frame {1'b1, addr[6:0], data[7:0]}
// shifted MSB first toward the on-chip SPI register-file peripheral.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   req        : requester handshakes (req0_*/req1_* valid, addr, data, ready)
//   busy       : high in every non-idle state
//   done       : one-cycle pulse on the first cycle after ncs rises
//   done_id    : requester index of the completed frame, valid with done
//   ncs        : chip select, active low
//   sclk       : SPI clock, idles low
//   sdi        : serial data toward the peripheral
module spi_cfg_master #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned GAP_CYC = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   spi_cfg_master_if.slave        req,
   output logic                   busy,
   output logic                   done,
   output logic                   done_id,
   output logic                   ncs,
   output logic                   sclk,
   output logic                   sdi
);
   localparam int unsigned MAX_CYC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
   localparam int unsigned CW = $clog2(MAX_CYC) + 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [4:0]    bit_cnt;
   logic [14:0]   shreg;
   logic          last_grant;
   logic          id;
   logic          grant;
   logic          take;
   logic          phase_end;
   logic [15:0]   frame_in;

   // Round-robin: on a tie the requester that did not win last time goes.
   always_comb begin
      grant = 1'b0;
      if (req.req0_valid && req.req1_valid)
         grant = ~last_grant;
      else if (req.req1_valid)
         grant = 1'b1;
   end

   assign req.req0_ready = (state == IDLE) && !grant;
   assign req.req1_ready = (state == IDLE) &&  grant;
   assign take           = grant ? req.req1_valid : req.req0_valid;
   assign frame_in       = grant ? {1'b1, req.req1_addr, req.req1_data}
                                 : {1'b1, req.req0_addr, req.req0_data};
   assign phase_end      = (cnt == DIV_LAST);

   // shreg holds the not-yet-driven bits frame[14:0]; bit 14 is always the
   // next bit to put on sdi when leaving SHIFT_HI.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         last_grant <= 1'b1;
         id         <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         done_id    <= 1'b0;
         ncs        <= 1'b1;
         sclk       <= 1'b0;
         sdi        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_cnt <= '0;
               if (take) begin
                  shreg      <= frame_in[14:0];
                  sdi        <= frame_in[15];
                  last_grant <= grant;
                  id         <= grant;
                  ncs        <= 1'b0;
                  sclk       <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SETUP;
               end
            end
            SETUP: begin
               if (phase_end) begin
                  cnt   <= '0;
                  sclk  <= 1'b1;
                  state <= SHIFT_HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (phase_end) begin
                  cnt     <= '0;
                  sclk    <= 1'b0;
                  bit_cnt <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd15) begin
                     state <= HOLD;
                  end else begin
                     sdi   <= shreg[14];
                     shreg <= {shreg[13:0], 1'b0};
                     state <= SHIFT_LO;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT_LO: begin
               if (phase_end) begin
                  cnt   <= '0;
                  sclk  <= 1'b1;
                  state <= SHIFT_HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (phase_end) begin
                  cnt     <= '0;
                  ncs     <= 1'b1;
                  sdi     <= 1'b0;
                  done    <= 1'b1;
                  done_id <= id;
                  state   <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
